// File: rtl/tester_pkg.sv
// Shared tester definitions: capture FSM state encoding, chain defaults and
// the capture latency formula used by the central FSM and the bench.
package tester_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SETTLE,
      S_SAMPLE,
      S_SHIFT_HI,
      S_SHIFT_LO,
      S_DONE
   } cap_state_t;

   localparam int DUT_WIDTH         = 128;
   localparam int CHAIN_CLK_DIV     = 4;
   localparam int CHAIN_LOAD_CYCLES = 2;

   // Cycles from the edge that samples START to the cycle DONE is high.
   function automatic int capture_latency(input int width,
                                          input int clk_div,
                                          input int load_cycles);
      return 1 + load_cycles + clk_div + width + 2 * clk_div * (width - 1);
   endfunction

   // Phase timer width; never collapses to zero bits.
   function automatic int timer_width(input int clk_div, input int load_cycles);
      int m;
      m = (clk_div > load_cycles) ? clk_div : load_cycles;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/phase_timer.sv
// Down-counter used to time FSM phases: load N-1 on state entry, expired
// reads high on the last cycle of the phase.
module phase_timer #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             expired
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign expired = (cnt == '0);

endmodule

// File: rtl/output_vector_capture.sv
// Reads the DUT response vector out of the parallel-in/serial-out chain,
// MSB first, and presents it as one WIDTH-bit word with a DONE pulse.
module output_vector_capture
   import tester_pkg::*;
#(
   parameter int WIDTH       = DUT_WIDTH,
   parameter int CLK_DIV     = CHAIN_CLK_DIV,
   parameter int LOAD_CYCLES = CHAIN_LOAD_CYCLES
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic             ABORT,
   input  logic             Q,
   output logic             PL_BAR,
   output logic             SHCP,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] VECTOR
);

   localparam int TW = timer_width(CLK_DIV, LOAD_CYCLES);
   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [TW-1:0] DIV_RELOAD  = TW'(CLK_DIV - 1);
   localparam logic [TW-1:0] LOAD_RELOAD = TW'(LOAD_CYCLES - 1);
   localparam logic [CW-1:0] BIT_LAST    = CW'(WIDTH - 1);

   cap_state_t       state;
   cap_state_t       state_next;
   logic [CW-1:0]    bit_cnt;
   logic [WIDTH-1:0] sr;
   logic             timer_load;
   logic [TW-1:0]    timer_val;
   logic             timer_expired;

   phase_timer #(
      .CNT_W (TW)
   ) u_phase_timer (
      .clk      (CLK),
      .rst      (RST),
      .load     (timer_load),
      .load_val (timer_val),
      .expired  (timer_expired)
   );

   always_comb begin
      state_next = state;
      timer_load = 1'b0;
      timer_val  = DIV_RELOAD;
      unique case (state)
         S_IDLE: begin
            if (START) begin
               state_next = S_LOAD;
               timer_load = 1'b1;
               timer_val  = LOAD_RELOAD;
            end
         end
         S_LOAD: begin
            if (timer_expired) begin
               state_next = S_SETTLE;
               timer_load = 1'b1;
            end
         end
         S_SETTLE: begin
            if (timer_expired) begin
               state_next = S_SAMPLE;
            end
         end
         S_SAMPLE: begin
            // The last sample goes straight to DONE so no trailing SHCP edge.
            if (bit_cnt == BIT_LAST) begin
               state_next = S_DONE;
            end else begin
               state_next = S_SHIFT_HI;
               timer_load = 1'b1;
            end
         end
         S_SHIFT_HI: begin
            if (timer_expired) begin
               state_next = S_SHIFT_LO;
               timer_load = 1'b1;
            end
         end
         S_SHIFT_LO: begin
            if (timer_expired) begin
               state_next = S_SAMPLE;
            end
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
      if (ABORT) begin
         state_next = S_IDLE;
      end
   end

   // Pin outputs are registered from the next state so they never glitch.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state   <= S_IDLE;
         bit_cnt <= '0;
         PL_BAR  <= 1'b1;
         SHCP    <= 1'b0;
         BUSY    <= 1'b0;
         DONE    <= 1'b0;
         VECTOR  <= '0;
      end else begin
         state  <= state_next;
         PL_BAR <= (state_next != S_LOAD);
         SHCP   <= (state_next == S_SHIFT_HI);
         BUSY   <= (state_next != S_IDLE);
         DONE   <= (state == S_DONE);
         if (state == S_IDLE && state_next == S_LOAD) begin
            bit_cnt <= '0;
         end else if (state == S_SAMPLE) begin
            bit_cnt <= bit_cnt + CW'(1);
         end
         if (state == S_DONE) begin
            VECTOR <= sr;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (state == S_SAMPLE) begin
         sr <= {sr[WIDTH-2:0], Q};
      end
   end

endmodule

// File: tb/tb_output_vector_capture.sv
// Bench for output_vector_capture: behavioural shift-register chain, a
// cycle-level model of the capture timeline and directed capture scenarios.
module tb_output_vector_capture;
   import tester_pkg::*;

   localparam int W = DUT_WIDTH;
   localparam int D = CHAIN_CLK_DIV;
   localparam int L = CHAIN_LOAD_CYCLES;
   localparam int N = capture_latency(W, D, L);

   logic         CLK = 1'b0;
   logic         RST = 1'b1;
   logic         START = 1'b0;
   logic         ABORT = 1'b0;
   logic         Q;
   logic         PL_BAR;
   logic         SHCP;
   logic         BUSY;
   logic         DONE;
   logic [W-1:0] VECTOR;

   output_vector_capture #(
      .WIDTH       (W),
      .CLK_DIV     (D),
      .LOAD_CYCLES (L)
   ) dut (
      .CLK    (CLK),
      .RST    (RST),
      .START  (START),
      .ABORT  (ABORT),
      .Q      (Q),
      .PL_BAR (PL_BAR),
      .SHCP   (SHCP),
      .BUSY   (BUSY),
      .DONE   (DONE),
      .VECTOR (VECTOR)
   );

   always #5 CLK = ~CLK;

   // Chain: parallel load on PL_BAR fall, shift toward the MSB on SHCP rise.
   logic [W-1:0] pattern = '0;
   logic [W-1:0] chain = '0;
   initial forever begin
      @(negedge PL_BAR or posedge SHCP);
      if (!PL_BAR) chain = pattern;
      else         chain = {chain[W-2:0], 1'b0};
   end
   assign Q = chain[W-1];

   // Timeline model: a capture is "active" for N cycles after START is taken;
   // m_t is the cycle offset within the capture.
   bit           m_active = 1'b0;
   bit           m_done   = 1'b0;
   int           m_t      = 0;
   logic [W-1:0] m_pat    = '0;
   logic [W-1:0] m_vec    = '0;

   initial forever begin
      @(posedge CLK or posedge RST);
      if (RST) begin
         m_active = 1'b0;
         m_done   = 1'b0;
         m_t      = 0;
         m_vec    = '0;
      end else begin
         m_done = 1'b0;
         if (m_active) begin
            if (m_t == N - 1) begin
               m_active = 1'b0;
               m_done   = 1'b1;
               m_vec    = m_pat;
            end else if (ABORT) begin
               m_active = 1'b0;
            end else begin
               m_t = m_t + 1;
            end
         end else if (START && !ABORT) begin
            m_active = 1'b1;
            m_t      = 0;
            m_pat    = pattern;
         end
      end
   end

   function automatic logic exp_shcp(input bit act, input int t);
      int u;
      u = t - (L + D + 1);
      return act && (u >= 0) && (u < (W - 1) * (2 * D + 1)) && ((u % (2 * D + 1)) < D);
   endfunction

   typedef struct {
      string        name;
      logic [W-1:0] act;
      logic [W-1:0] exp;
   } dchk_t;

   dchk_t dq[$];
   int    n_checks = 0;
   int    n_errs   = 0;
   int    tot_rise = 0;
   int    tot_pl_low = 0;
   int    tot_done = 0;
   int    hi_run = 0;
   int    hi_min = 1 << 30;
   int    hi_max = 0;
   logic  prev_shcp = 1'b0;

   task automatic expect_eq(input string nm, input logic [W-1:0] a, input logic [W-1:0] e);
      dchk_t c;
      c.name = nm;
      c.act  = a;
      c.exp  = e;
      dq.push_back(c);
   endtask

   task automatic expect_int(input string nm, input int a, input int e);
      expect_eq(nm, W'(a), W'(e));
   endtask

   // Single compare process: per-cycle model check, pin statistics, and
   // evaluation of directed expectations queued by the stimulus.
   initial forever begin
      logic [3:0] ctl_exp;
      logic [3:0] ctl_act;
      dchk_t      c;
      @(negedge CLK);
      if (!RST) begin
         ctl_exp = {!(m_active && m_t < L), exp_shcp(m_active, m_t), m_active, m_done};
         ctl_act = {PL_BAR, SHCP, BUSY, DONE};
         n_checks++;
         if (ctl_act !== ctl_exp || VECTOR !== m_vec) begin
            n_errs++;
            $display("FAIL cycle @%0t pl/shcp/busy/done got %b expected %b, vector got %h expected %h",
                     $time, ctl_act, ctl_exp, VECTOR, m_vec);
         end
         if (SHCP && !prev_shcp) tot_rise++;
         if (!PL_BAR) tot_pl_low++;
         if (DONE) tot_done++;
         if (SHCP) begin
            hi_run++;
         end else if (prev_shcp) begin
            if (hi_run < hi_min) hi_min = hi_run;
            if (hi_run > hi_max) hi_max = hi_run;
            hi_run = 0;
         end
         prev_shcp = SHCP;
      end else begin
         prev_shcp = 1'b0;
         hi_run    = 0;
      end
      while (dq.size() > 0) begin
         c = dq.pop_front();
         n_checks++;
         if (c.act !== c.exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", c.name, c.act, c.exp);
         end
      end
   end

   task automatic capture(input logic [W-1:0] pat, input int rp1, input int rp2,
                          input int ab_at, input logic [W-1:0] keep_vec,
                          output int lat, output int rises, output int pl_low,
                          output int dones);
      int r0, p0, d0;
      bit got;
      pattern = pat;
      @(negedge CLK); #1;
      r0 = tot_rise; p0 = tot_pl_low; d0 = tot_done;
      START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
      lat = 0;
      got = 1'b0;
      while (!got && lat < N + 20) begin
         @(posedge CLK); #1;
         lat++;
         got   = DONE;
         START = (lat == rp1) || (lat == rp2);
         ABORT = (lat == ab_at);
         if (ab_at >= 0 && lat == ab_at + 1) begin
            expect_eq("abort_busy", W'(BUSY), W'(1'b0));
            expect_eq("abort_pl_bar", W'(PL_BAR), W'(1'b1));
            expect_eq("abort_shcp", W'(SHCP), W'(1'b0));
            expect_eq("abort_done", W'(DONE), W'(1'b0));
            expect_eq("abort_vector", VECTOR, keep_vec);
         end
      end
      START = 1'b0;
      ABORT = 1'b0;
      if (!got) lat = -1;
      @(negedge CLK); #1;
      rises  = tot_rise - r0;
      pl_low = tot_pl_low - p0;
      dones  = tot_done - d0;
   endtask

   localparam logic [W-1:0] P_BEEF = 128'hDEADBEEF_0123_4567_89AB_CDEF_F00D_CAFE;
   localparam logic [W-1:0] P_ONES = {W{1'b1}};
   localparam logic [W-1:0] P_ZERO = '0;
   localparam logic [W-1:0] P_AAAA = {(W/2){2'b10}};
   localparam logic [W-1:0] P_5555 = {(W/2){2'b01}};
   localparam logic [W-1:0] P_MIX  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3211;

   initial begin
      int lat, rises, pl_low, dones, cyc, last, k;
      logic [W-1:0] pats [3];
      logic [W-1:0] seq [3];

      repeat (3) @(negedge CLK);
      expect_eq("reset_pl_bar", W'(PL_BAR), W'(1'b1));
      expect_eq("reset_shcp", W'(SHCP), W'(1'b0));
      expect_eq("reset_busy", W'(BUSY), W'(1'b0));
      expect_eq("reset_done", W'(DONE), W'(1'b0));
      expect_eq("reset_vector", VECTOR, P_ZERO);
      RST = 1'b0;
      repeat (3) @(negedge CLK);

      capture(P_BEEF, -1, -1, -1, P_ZERO, lat, rises, pl_low, dones);
      expect_int("beef_latency", lat, 1151);
      expect_eq("beef_vector", VECTOR, 128'hDEADBEEF_0123_4567_89AB_CDEF_F00D_CAFE);
      expect_int("beef_shcp_rises", rises, 127);
      expect_int("beef_pl_low_cycles", pl_low, 2);
      expect_int("beef_done_pulses", dones, 1);
      expect_int("shcp_high_min", hi_min, 4);
      expect_int("shcp_high_max", hi_max, 4);

      seq[0] = P_ONES; seq[1] = P_ZERO; seq[2] = P_AAAA;
      for (int i = 0; i < 3; i++) begin
         capture(seq[i], -1, -1, -1, P_ZERO, lat, rises, pl_low, dones);
         expect_eq("pattern_vector", VECTOR, seq[i]);
         expect_eq("pattern_bit127", W'(VECTOR[W-1]), W'(seq[i][W-1]));
         expect_eq("pattern_bit0", W'(VECTOR[0]), W'(seq[i][0]));
      end

      capture(P_MIX, 10, 500, -1, P_ZERO, lat, rises, pl_low, dones);
      expect_int("repulse_latency", lat, 1151);
      expect_int("repulse_done_pulses", dones, 1);
      expect_int("repulse_shcp_rises", rises, 127);
      expect_eq("repulse_vector", VECTOR, P_MIX);

      capture(P_5555, -1, -1, -1, P_ZERO, lat, rises, pl_low, dones);
      expect_eq("p5555_vector", VECTOR, P_5555);
      capture(P_BEEF, -1, -1, 600, P_5555, lat, rises, pl_low, dones);
      expect_int("abort_done_pulses", dones, 0);
      expect_eq("abort_vector_kept", VECTOR, P_5555);
      capture(P_MIX, -1, -1, -1, P_ZERO, lat, rises, pl_low, dones);
      expect_eq("after_abort_vector", VECTOR, P_MIX);
      expect_int("after_abort_latency", lat, 1151);

      @(negedge CLK);
      START = 1'b1;
      ABORT = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
      ABORT = 1'b0;
      expect_eq("start_abort_busy", W'(BUSY), W'(1'b0));
      expect_eq("start_abort_pl_bar", W'(PL_BAR), W'(1'b1));

      pats[0] = P_AAAA; pats[1] = P_BEEF; pats[2] = P_5555;
      pattern = pats[0];
      @(negedge CLK);
      START = 1'b1;
      cyc = 0; last = 0; k = 0;
      while (k < 3 && cyc < 4 * (N + 1)) begin
         @(posedge CLK); #1;
         cyc++;
         if (DONE) begin
            expect_eq("held_vector", VECTOR, pats[k]);
            if (k > 0) expect_int("held_period", cyc - last, 1152);
            last = cyc;
            k++;
            if (k < 3) pattern = pats[k];
            else START = 1'b0;
         end
      end
      START = 1'b0;
      expect_int("held_done_count", k, 3);
      repeat (3) @(negedge CLK);

      pattern = P_MIX;
      @(negedge CLK);
      START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
      cyc = 0;
      while (!SHCP && cyc < 100) begin
         @(posedge CLK); #1;
         cyc++;
      end
      expect_eq("rst_reached_shift_hi", W'(SHCP), W'(1'b1));
      expect_eq("rst_prior_vector", VECTOR, P_5555);
      #2;
      RST = 1'b1;
      #1;
      expect_eq("rst_async_shcp", W'(SHCP), W'(1'b0));
      expect_eq("rst_async_busy", W'(BUSY), W'(1'b0));
      expect_eq("rst_async_pl_bar", W'(PL_BAR), W'(1'b1));
      expect_eq("rst_async_vector", VECTOR, P_ZERO);
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      repeat (2) @(negedge CLK);

      capture(P_BEEF, -1, -1, -1, P_ZERO, lat, rises, pl_low, dones);
      expect_eq("post_rst_vector", VECTOR, P_BEEF);
      expect_int("post_rst_latency", lat, 1151);
      expect_int("post_rst_shcp_rises", rises, 127);

      repeat (2) @(negedge CLK);
      #1;
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/output_vector_capture.md
Name: output_vector_capture

Overview:
- Reads the DUT response vector from the external parallel-in/serial-out shift-register chain, one bit per shift clock on Q.
- Returns it to the central tester FSM as one WIDTH-bit word.
- Sits directly upstream of the central FSM's FETCH_OUTPUT_VECTOR state. That state pulses START, waits for DONE, then latches VECTOR for SRAM storage or UART transmission.
- Drives the chain's PL_BAR and SHCP pins. The central FSM muxes these onto the board pins while this block is BUSY.

Parameters:
WIDTH, 128, number of bits in the chain; must be >= 2
CLK_DIV, 4, system cycles per SHCP half-period and per settle interval; must be >= 1
LOAD_CYCLES, 2, system cycles PL_BAR is held low; must be >= 1

Ports:
CLK  input  1  system clock
RST  input  1  reset
START  input  1  capture request; level-sampled, accepted only in IDLE
ABORT  input  1  soft-reset request from the central FSM; synchronous, highest priority after RST
Q  input  1  serial data from the last stage of the chain
PL_BAR  output  1  parallel-load strobe to the chain, active low
SHCP  output  1  chain shift clock; chain shifts on the rising edge
BUSY  output  1  high from LOAD through DONE inclusive
DONE  output  1  one-cycle pulse: VECTOR was updated this cycle
VECTOR  output  WIDTH  last completed capture

Behaviour:
- Reset: CLK is the single clock; RST is asynchronous, active-high.
  - While RST is high: PL_BAR=1, SHCP=0, BUSY=0, DONE=0, VECTOR=0, state=IDLE, counters=0.
- States:
  - IDLE: PL_BAR=1, SHCP=0. START=1 and ABORT=0 -> LOAD. Otherwise stay in IDLE.
  - LOAD: PL_BAR=0 for exactly LOAD_CYCLES cycles -> SETTLE.
  - SETTLE: PL_BAR=1, SHCP=0 for CLK_DIV cycles -> SAMPLE. After SETTLE, Q presents the chain MSB (bit WIDTH-1).
  - SAMPLE: one cycle.
    - Shift register {sr[WIDTH-2:0], Q} is captured on this cycle's edge; bit_cnt increments.
    - If bit_cnt was WIDTH-1 -> DONE. Otherwise -> SHIFT_HI.
  - SHIFT_HI: SHCP=1 for CLK_DIV cycles -> SHIFT_LO.
  - SHIFT_LO: SHCP=0 for CLK_DIV cycles -> SAMPLE.
  - DONE: one cycle.
    - VECTOR <= completed shift register, so the first bit sampled lands in VECTOR[WIDTH-1].
    - DONE=1 -> IDLE.
- Counts:
  - Exactly WIDTH samples and WIDTH-1 SHCP rising edges per capture.
  - No SHCP edge occurs after the final sample.
- Latency:
  - DONE is high exactly 1+LOAD_CYCLES+CLK_DIV+WIDTH+2*CLK_DIV*(WIDTH-1) cycles after the edge that sampled START.
  - With the defaults this is 1151 cycles.
- Pin outputs: PL_BAR and SHCP are driven from flops with no combinational glitches; they change only on CLK edges.
- Q is sampled directly. CLK_DIV must cover the chain's clock-to-Q delay plus board delay.
- Widths:
  - bit_cnt is clog2(WIDTH+1) bits and saturates nowhere; it is cleared on LOAD entry.
  - The phase timer is clog2(max(CLK_DIV,LOAD_CYCLES)) bits and loads N-1 on state entry.
- Boundary rules:
  - START while BUSY: ignored; there is no queueing and no restart.
  - START held high continuously: a new capture begins the cycle after DONE, giving a period of N+1 cycles (1152 with defaults).
  - ABORT in any non-IDLE state: IDLE on the next edge, with PL_BAR=1, SHCP=0, BUSY=0. No DONE pulse; VECTOR keeps its previous value.
  - ABORT and START together in IDLE: ABORT wins and the block stays in IDLE.
  - ABORT in the DONE cycle: VECTOR update and the DONE pulse still complete, since DONE is a single cycle; the next state is IDLE either way.
  - RST mid-capture: all outputs take reset values asynchronously and VECTOR clears to 0.
- VECTOR is stable at all times except the DONE-cycle edge.

Decomposition:
- Shared package tester_pkg holds:
  - the capture state encoding (IDLE, LOAD, SETTLE, SAMPLE, SHIFT_HI, SHIFT_LO, DONE);
  - defaults DUT_WIDTH=128, CHAIN_CLK_DIV=4, CHAIN_LOAD_CYCLES=2;
  - the latency formula as a constant function, so the central FSM and the bench share it.
- One sub-module: phase_timer.
  - Down-counter with LOAD value, LOAD strobe and EXPIRED flag.
  - Reused by the input-vector shift-out stage and by the central FSM's cycle timing.

Test Plan:
- Behavioural chain model loaded with 128'hDEADBEEF_0123_4567_89AB_CDEF_F00D_CAFE, START pulse -> VECTOR equals the pattern; DONE is a single pulse 1151 cycles after START; PL_BAR low exactly 2 cycles; exactly 127 SHCP rising edges, each high 4 cycles.
- Chain all-ones, then all-zeros, then 128'hAAAA...A -> VECTOR matches each pattern with MSB first; no bit reversal or off-by-one at bit 0 or bit 127.
- START re-pulsed at cycles 10 and 500 of a capture -> exactly one DONE at 1151; SHCP edge count stays 127.
- Capture 128'h5555...5, then START a second capture and ABORT at cycle 600 -> next cycle IDLE, BUSY=0, PL_BAR=1, SHCP=0, no DONE, VECTOR still 128'h5555...5; a fresh START then captures correctly.
- Assert RST asynchronously mid-SHIFT_HI (between CLK edges) -> SHCP drops to 0, BUSY=0, VECTOR=0 before the next CLK edge.
- START held high, chain pattern changed each capture -> DONE pulses every 1152 cycles; each VECTOR matches the pattern loaded at its LOAD phase.
